// File: rtl/izh_weight_sequencer.sv
// Weight RAM loader and synaptic read sweeper for the Izhikevich neuron block.
// Optional running checksum of loaded words, enabled by defining IZH_WSEQ_CHECKSUM_EN.
module izh_weight_sequencer #(
    parameter int NEURON_ADR = 4,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD_START,
    input  logic                  RUN_START,
    input  logic [NEURON_ADR:0]   RUN_LEN,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_W-1:0]     S_DATA,
    output logic                  WE,
    output logic [NEURON_ADR:0]   A,
    output logic [DATA_W-1:0]     DI,
    output logic [NEURON_ADR:0]   DPRA,
    output logic                  EN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_W-1:0]     CHECKSUM
);

    // state | meaning
    // IDLE  | waiting for LOAD_START / RUN_START
    // LOAD  | accepting weight words, writing each one cycle after its handshake
    // RUN   | sweeping DPRA 0..run_len with EN high
    // DONE  | single-cycle completion pulse, final LOAD write lands here
    localparam int AW = NEURON_ADR + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [AW-1:0] LAST_WR = AW'(DEPTH - 1);

    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] run_len_q;
    logic          hs;

    assign hs   = S_VALID & S_READY;
    assign DPRA = rd_ptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            run_len_q <= '0;
            S_READY   <= 1'b0;
            WE        <= 1'b0;
            A         <= '0;
            DI        <= '0;
            EN        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            WE   <= 1'b0;
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    // LOAD has priority when both starts arrive together
                    if (LOAD_START) begin
                        state   <= LOAD;
                        wr_ptr  <= '0;
                        S_READY <= 1'b1;
                        BUSY    <= 1'b1;
                    end else if (RUN_START) begin
                        state     <= RUN;
                        rd_ptr    <= '0;
                        run_len_q <= RUN_LEN;
                        EN        <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        WE     <= 1'b1;
                        A      <= wr_ptr;
                        DI     <= S_DATA;
                        wr_ptr <= wr_ptr + AW'(1);
                        if (wr_ptr == LAST_WR) begin
                            state   <= FIN;
                            S_READY <= 1'b0;
                            DONE    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd_ptr == run_len_q) begin
                        state  <= FIN;
                        rd_ptr <= '0;
                        EN     <= 1'b0;
                        DONE   <= 1'b1;
                    end else begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IZH_WSEQ_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            checksum_q <= '0;
        end else if (state == IDLE && LOAD_START) begin
            checksum_q <= '0;
        end else if (state == LOAD && hs) begin
            checksum_q <= checksum_q + S_DATA;
        end
    end

    assign CHECKSUM = checksum_q;
`else
    assign CHECKSUM = '0;
`endif

endmodule
